// File: rtl/shift_sequence_ctrl.sv
// Sequences an external right-shifting JK register: preset/clear, N shifts, capture; done at cycle N+2 after start.
// Optional SHIFT_SEQUENCE_CTRL_ABORT_EN adds an abort input that jumps straight to FINISH.
module shift_sequence_ctrl #(
    parameter int WIDTH       = 4,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clockpulse,
    input  logic                   clear,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [COUNT_WIDTH-1:0] shiftCount,
    input  logic [WIDTH-1:0]       loadData,
    input  logic                   serialData,
    input  logic [WIDTH-1:0]       regOut,
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
    input  logic                   abort,
`endif
    output logic [WIDTH-1:0]       regPreset,
    output logic                   regEnablePreset,
    output logic                   regClear,
    output logic                   regShiftEnable,
    output logic                   regSerialInput,
    output logic                   serialOut,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [WIDTH-1:0]       captured
);

    typedef enum logic [1:0] {IDLE, PREP, SHIFT, FINISH} state_t;

    localparam logic [1:0] MODE_OUT = 2'b00;
    localparam logic [1:0] MODE_IN  = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;
    localparam logic [1:0] MODE_BAD = 2'b11;

    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] cnt_q;
    logic [COUNT_WIDTH-1:0] cnt_d;
    logic [1:0]             mode_q;
    logic [WIDTH-1:0]       preset_q;
    logic                   preset_en_q;
    logic                   clr_q;
    logic                   shift_en_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [WIDTH-1:0]       captured_q;
    logic                   abort_w;

`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // A zero count field means a full-width pass.
    assign cnt_d = (shiftCount == '0) ? COUNT_WIDTH'(WIDTH) : shiftCount;

    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= MODE_OUT;
            preset_q    <= '0;
            preset_en_q <= 1'b0;
            clr_q       <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            captured_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (mode == MODE_BAD) begin
                            error_q <= 1'b1;
                        end else begin
                            mode_q  <= mode;
                            cnt_q   <= cnt_d;
                            busy_q  <= 1'b1;
                            state_q <= PREP;
                            if (mode == MODE_IN) begin
                                clr_q <= 1'b1;
                            end else begin
                                preset_en_q <= 1'b1;
                                preset_q    <= loadData;
                            end
                        end
                    end
                end
                PREP: begin
                    preset_en_q <= 1'b0;
                    preset_q    <= '0;
                    clr_q       <= 1'b0;
                    if (abort_w) begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        shift_en_q <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The shift in this cycle still happens; abort only prevents further ones.
                    if (abort_w || cnt_q == COUNT_WIDTH'(1)) begin
                        shift_en_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= FINISH;
                    end else begin
                        cnt_q <= cnt_q - COUNT_WIDTH'(1);
                    end
                end
                FINISH: begin
                    busy_q     <= 1'b0;
                    captured_q <= regOut;
                    cnt_q      <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign regPreset       = preset_q;
    assign regEnablePreset = preset_en_q;
    assign regClear        = clr_q;
    assign regShiftEnable  = shift_en_q;
    assign regSerialInput  = shift_en_q & ((mode_q == MODE_IN)  ? serialData :
                                          (mode_q == MODE_ROT) ? regOut[0]  : 1'b0);
    assign serialOut       = regOut[0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign captured        = captured_q;

endmodule

// File: tb/tb_shift_sequence_ctrl.sv
// Scoreboard bench for shift_sequence_ctrl with a behavioural model of the external shift register.
module tb_shift_sequence_ctrl;
    localparam int W  = 4;
    localparam int CW = 3;

    logic          clockpulse = 1'b0;
    logic          clear      = 1'b1;
    logic          start      = 1'b0;
    logic [1:0]    mode       = 2'b00;
    logic [CW-1:0] shiftCount = '0;
    logic [W-1:0]  loadData   = '0;
    logic          serialData = 1'b0;
    logic [W-1:0]  regOut     = '0;
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
    logic          abort      = 1'b0;
`endif
    logic [W-1:0]  regPreset;
    logic          regEnablePreset, regClear, regShiftEnable, regSerialInput;
    logic          serialOut, busy, done, error;
    logic [W-1:0]  captured;

    shift_sequence_ctrl #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clockpulse(clockpulse), .clear(clear), .start(start), .mode(mode),
        .shiftCount(shiftCount), .loadData(loadData), .serialData(serialData),
        .regOut(regOut),
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
        .abort(abort),
`endif
        .regPreset(regPreset), .regEnablePreset(regEnablePreset), .regClear(regClear),
        .regShiftEnable(regShiftEnable), .regSerialInput(regSerialInput),
        .serialOut(serialOut), .busy(busy), .done(done), .error(error),
        .captured(captured)
    );

    always #5 clockpulse = ~clockpulse;

    // External JK shift register the controller drives.
    always @(posedge clockpulse) begin
        if (regClear)             regOut <= '0;
        else if (regEnablePreset) regOut <= regPreset;
        else if (regShiftEnable)  regOut <= {regSerialInput, regOut[W-1:1]};
    end

    int cyc = 0;
    always @(posedge clockpulse) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Register contents after k shifts, from the command's rules.
    function automatic logic [3:0] ref_reg(input int md, input logic [3:0] ld,
                                           input logic [7:0] bits, input int k);
        logic [7:0] t;
        logic [3:0] v;
        v = '0;
        if (md == 0) begin
            v = (k >= 4) ? 4'b0000 : (ld >> k);
        end else if (md == 2) begin
            t = {ld, ld} >> (k % 4);
            v = t[3:0];
        end else begin
            for (int j = 0; j < 4; j++)
                if (k - 4 + j >= 0) v[j] = bits[k - 4 + j];
        end
        return v;
    endfunction

    typedef struct {
        logic [3:0] cap;
        int         done_cyc;
        int         busy_len;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic err_exp = 1'b0;

    int bcnt   = 0;
    int dcyc   = -1;
    int dcount = 0;
    always @(negedge clockpulse) begin
        if (clear) begin
            bcnt = 0; dcyc = -1; dcount = 0;
        end else begin
            if (error || err_exp) chk("error_pulse", 32'(error), 32'(err_exp));
            if (done) begin dcyc = cyc; dcount++; end
            if (busy) bcnt++;
            else if (bcnt > 0) begin
                if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
                else begin
                    mon_e = sb.pop_front();
                    chk("captured",    32'(captured), 32'(mon_e.cap));
                    chk("done_cycle",  32'(dcyc),     32'(mon_e.done_cyc));
                    chk("busy_len",    32'(bcnt),     32'(mon_e.busy_len));
                    chk("done_pulses", 32'(dcount),   32'd1);
                end
                bcnt = 0; dcyc = -1; dcount = 0;
            end
        end
    end

    // abort_at: -1 none, 0 during PREP, k during the k-th SHIFT cycle (1-based).
    task automatic run_cmd(input int md, input int sc, input logic [3:0] ld,
                           input logic [7:0] bits, input int abort_at, input bit junk);
        int n, s, c0;
        logic [3:0] r;
        logic sin;
        exp_t e;
        n = (sc == 0) ? 4 : sc;
        s = n;
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
        if (abort_at == 0) s = 0;
        else if (abort_at > 0 && abort_at <= n) s = abort_at;
`endif
        @(negedge clockpulse);
        start = 1'b1; mode = 2'(md); shiftCount = CW'(sc); loadData = ld;
        @(posedge clockpulse); #1;
        c0 = cyc;
        start = 1'b0;
        e.cap = ref_reg(md, ld, bits, s); e.done_cyc = c0 + s + 1; e.busy_len = s + 2;
        sb.push_back(e);
        mode = 2'($urandom); loadData = 4'($urandom); shiftCount = CW'($urandom);
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
        abort = (abort_at == 0);
`endif
        chk("prep_ctl", 32'({busy, regEnablePreset, regClear, regShiftEnable, regPreset}),
            32'({1'b1, md != 1, md == 1, 1'b0, (md == 1) ? 4'b0000 : ld}));
        @(posedge clockpulse); #1;
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        for (int k = 0; k < s; k++) begin
            serialData = bits[k];
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
            abort = (k + 1 == abort_at);
`endif
            if (junk && k == 0) start = 1'b1;
            #1;
            r   = ref_reg(md, ld, bits, k);
            sin = (md == 1) ? bits[k] : (md == 2) ? r[0] : 1'b0;
            chk("shift_ctl", 32'({busy, regEnablePreset, regClear, regShiftEnable, regPreset}),
                32'({1'b1, 1'b0, 1'b0, 1'b1, 4'b0000}));
            chk("serial_out", 32'(serialOut), 32'(r[0]));
            chk("serial_in",  32'(regSerialInput), 32'(sin));
            @(posedge clockpulse); #1;
            start = 1'b0;
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
            abort = 1'b0;
`endif
        end
        chk("finish_ctl", 32'({busy, done, regEnablePreset, regClear, regShiftEnable}), 32'(5'b11000));
        @(posedge clockpulse); #1;
        chk("idle_ctl", 32'({busy, done}), 32'd0);
    endtask

    task automatic illegal_cmd();
        @(negedge clockpulse);
        start = 1'b1; mode = 2'b11; shiftCount = CW'($urandom); loadData = 4'($urandom);
        @(posedge clockpulse); #1;
        start = 1'b0;
        err_exp = 1'b1;
        chk("illegal_busy", 32'(busy), 32'd0);
        @(posedge clockpulse); #1;
        err_exp = 1'b0;
        chk("illegal_idle", 32'({busy, error}), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clockpulse);
        #1;
        chk("reset_outputs", 32'({busy, done, error, regEnablePreset, regClear, regShiftEnable,
                                  regSerialInput, regPreset, captured}), 32'd0);
        chk("reset_serial_out", 32'(serialOut), 32'(regOut[0]));
        @(negedge clockpulse); #1;
        clear = 1'b0;

        run_cmd(0, 0, 4'b1011, 8'h00, -1, 1'b0);
        run_cmd(2, 1, 4'b0001, 8'h00, -1, 1'b0);
        run_cmd(2, 4, 4'b0001, 8'h00, -1, 1'b0);
        run_cmd(2, 5, 4'b0001, 8'h00, -1, 1'b0);
        run_cmd(1, 4, 4'b1111, 8'b0000_0011, -1, 1'b0);

        // Clear mid-SHIFT of a count-4 command: aborted without a done pulse.
        @(negedge clockpulse);
        start = 1'b1; mode = 2'b00; shiftCount = 3'd4; loadData = 4'b1110;
        @(posedge clockpulse); #1;
        start = 1'b0;
        repeat (2) @(posedge clockpulse);
        #1;
        clear = 1'b1;
        #1;
        chk("midrun_reset", 32'({busy, done, error, regEnablePreset, regClear, regShiftEnable,
                                 regSerialInput, regPreset, captured}), 32'd0);
        @(negedge clockpulse); #1;
        clear = 1'b0;

        run_cmd(2, 3, 4'b0110, 8'h00, -1, 1'b0);
        illegal_cmd();
        run_cmd(1, 6, 4'b0000, 8'b0010_1101, -1, 1'b1);
        run_cmd(2, 4, 4'b0001, 8'h00, 2, 1'b0);
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
        run_cmd(0, 3, 4'b1001, 8'h00, 0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            int ab;
            ab = -1;
`ifdef SHIFT_SEQUENCE_CTRL_ABORT_EN
            if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 8);
`endif
            if ($urandom_range(0, 9) == 0) illegal_cmd();
            else run_cmd($urandom_range(0, 2), $urandom_range(0, 7), 4'($urandom),
                         8'($urandom), ab, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clockpulse);
        end

        repeat (5) @(posedge clockpulse);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequence_ctrl.md
Name: shift_sequence_ctrl

Overview:
- Controller that sequences an external right-shifting 4-bit JK shift register.
- The register's serial input enters bit 3, each bit i takes bit i+1, and bit 0 is the serial output.
- Accepts a command (start, mode, count, load word) and drives the register's clear, preset, preset-enable, shift-enable and serial input.
- Runs the requested number of shifts, then returns the final register contents with a done pulse.
- Sits between the lab's command logic and the shift-register datapath.

Parameters:
- WIDTH, 4, register width in bits.
- COUNT_WIDTH, 3, width of the shift-count field and the internal shift counter.

Ports:
- clockpulse  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  command strobe; sampled in IDLE only.
- mode  input  2  00 shift-out, 01 shift-in, 10 rotate, 11 illegal.
- shiftCount  input  COUNT_WIDTH  number of shifts; 0 means WIDTH.
- loadData  input  WIDTH  parallel word for shift-out/rotate.
- serialData  input  1  serial bit for shift-in mode.
- regOut  input  WIDTH  current register contents.
- regPreset  output  WIDTH  preset word to register.
- regEnablePreset  output  1  register parallel-load enable.
- regClear  output  1  register clear.
- regShiftEnable  output  1  register shifts on next rising edge when 1.
- regSerialInput  output  1  bit shifted into register bit 3.
- serialOut  output  1  equals regOut[0], registered-through combinationally.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- error  output  1  one-cycle pulse on illegal mode.
- captured  output  WIDTH  register contents latched at completion.

Behaviour:
- Reset (clear=1, asynchronous): state IDLE; all outputs 0 except serialOut (=regOut[0]); captured=0; internal counter and latched command cleared.
- Reset mid-operation aborts immediately; no done pulse.
- States: IDLE, PREP, SHIFT, FINISH.
- IDLE: if start=1 and mode!=11, latch mode, loadData and effective count (shiftCount==0 → WIDTH), then go to PREP. If start=1 and mode==11, pulse error for one cycle and stay in IDLE.
- PREP (1 cycle), busy=1:
  - shift-out and rotate: regEnablePreset=1, regPreset=latched loadData.
  - shift-in: regClear=1.
  - Then go to SHIFT.
- SHIFT (exactly count cycles), busy=1, regShiftEnable=1. Counter loads count in PREP and decrements each SHIFT cycle; leave SHIFT when counter reaches 1 at the clock edge. regSerialInput by mode:
  - shift-out: 0.
  - shift-in: serialData (live).
  - rotate: regOut[0].
- FINISH (1 cycle): busy=1, done=1, captured<=regOut at the end of this cycle; go to IDLE.
- Latency: start sampled at edge 0; PREP cycle 1; SHIFT cycles 2..count+1; FINISH cycle count+2; busy low again from cycle count+3. Back-to-back start accepted on the first IDLE cycle.
- Outside their active states, regPreset/regEnablePreset/regClear/regShiftEnable/regSerialInput are 0.
- start during busy is ignored (no queueing, no error).
- count > WIDTH is legal: extra shifts fill with the serial source, so rotate wraps.
- The register model assumed: preset and clear are applied on the PREP edge; one shift per regShiftEnable cycle.

Optional Feature:
- Macro: SHIFT_SEQUENCE_CTRL_ABORT_EN.
- With macro: adds input port abort (1 bit).
  - abort=1 in PREP or SHIFT → next state FINISH, shifting stops that cycle, done pulses, captured takes the current regOut.
  - abort in IDLE or FINISH has no effect.
  - abort has priority over counter expiry.
- Without macro: no abort port; commands always run to completion.

Test Plan:
- Reset: assert clear mid-SHIFT of a count-4 command → busy=0, done=0, all reg* outputs 0, captured=0, next start accepted normally.
- Shift-out: mode=00, loadData=4'b1011, shiftCount=0 → PREP preset 1011; serialOut 1,1,0,1 on cycles 1..4 after PREP; done at cycle 6 after start; captured=4'b0000.
- Shift-in: mode=01, shiftCount=4, serialData 1,1,0,0 on SHIFT cycles → regClear pulse in PREP; captured=4'b0011; busy high exactly 6 cycles.
- Rotate: mode=10, loadData=4'b0001, shiftCount=1 → captured=4'b1000. Repeat with shiftCount=4 → captured=4'b0001. shiftCount=5 → captured=4'b1000.
- Illegal and ignored commands: mode=11 with start → error high one cycle, busy stays 0. start pulsed while busy → no effect on count or captured.
- Abort (macro defined): rotate 4'b0001 count 4, abort on second SHIFT cycle → done next cycle, captured=4'b0100. Macro undefined: the same command completes with captured=4'b0001.
